// File: rtl/seg_scan_if.sv
`timescale 1ns/1ps
// Load handshake, display settings and multiplexed display bus of the
// segment scan controller. The pattern source is the master.
interface seg_scan_if #(
    parameter int DIGITS = 10
);
    logic [4*DIGITS-1:0] data_in;
    logic                load_req;
    logic                load_ack;
    logic                blank_lz;
    logic [3:0]          bright;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   dig_n;
    logic                frame_start;

    modport master (
        output data_in, load_req, blank_lz, bright,
        input  load_ack, seg_n, dig_n, frame_start
    );

    modport slave (
        input  data_in, load_req, blank_lz, bright,
        output load_ack, seg_n, dig_n, frame_start
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Time-multiplexed 7-segment scan controller: double-buffered display word
// swapped at frame boundaries, PWM brightness and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DIGITS  = 10,
    parameter int DIV_MAX = 49999
) (
    input  logic     clk,
    input  logic     rst_n,
    seg_scan_if.slave bus
);
    localparam int PW    = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NSLOT = 1 << IW;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV_MAX);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]          prescaler_reg;
    logic [IW-1:0]          idx_reg;
    logic [3:0]             pwm_reg;
    logic [4*DIGITS-1:0]    live_reg;
    logic [4*DIGITS-1:0]    pending_reg;
    logic                   pend_v_reg;
    logic                   req_d_reg;
    logic                   armed_reg;
    logic                   load_ack_reg;
    logic                   frame_start_reg;
    logic [6:0]             seg_n_reg;
    logic [DIGITS-1:0]      dig_n_reg;

    logic                   tick;
    logic                   wrap_tick;
    logic                   rise;
    logic                   en;
    logic [6:0]             seg_next;
    logic [DIGITS-1:0]      dig_next;
    logic [DIGITS-1:0]      dig_sel;
    logic [3:0]             live_dig  [NSLOT];
    logic                   blank_dig [NSLOT];

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Per-digit views of the live word; slots past DIGITS are never selected
    // but are tied off so idx can index the array without range trouble.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_dig
                assign live_dig[gi] = live_reg[4*gi +: 4];
                assign dig_sel[gi]  = (idx_reg != IW'(gi));
                if (gi == 0) begin : g_lsd
                    assign blank_dig[gi] = 1'b0;
                end else begin : g_upper
                    assign blank_dig[gi] = bus.blank_lz & ~|live_reg[4*DIGITS-1:4*gi];
                end
            end else begin : g_pad
                assign live_dig[gi]  = 4'h0;
                assign blank_dig[gi] = 1'b1;
            end
        end
    endgenerate

    assign tick      = (prescaler_reg == PRE_LAST);
    assign wrap_tick = tick && (idx_reg == IDX_LAST);
    // armed_reg keeps a request held high across reset from counting as an edge.
    assign rise      = bus.load_req && !req_d_reg && armed_reg;

    always_comb begin
        en       = ((bus.bright == 4'hF) || (pwm_reg < bus.bright)) && !tick && !blank_dig[idx_reg];
        seg_next = 7'h7F;
        dig_next = '1;
        if (en) begin
            seg_next = seg_decode(live_dig[idx_reg]);
            dig_next = dig_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_reg   <= '0;
            idx_reg         <= '0;
            pwm_reg         <= 4'h0;
            live_reg        <= '0;
            pending_reg     <= '0;
            pend_v_reg      <= 1'b0;
            req_d_reg       <= 1'b0;
            armed_reg       <= 1'b0;
            load_ack_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            seg_n_reg       <= 7'h7F;
            dig_n_reg       <= '1;
        end else begin
            req_d_reg       <= bus.load_req;
            if (!bus.load_req) begin
                armed_reg <= 1'b1;
            end
            load_ack_reg    <= rise;
            frame_start_reg <= wrap_tick;

            if (tick) begin
                prescaler_reg <= '0;
                idx_reg       <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
                pwm_reg       <= 4'h0;
            end else begin
                prescaler_reg <= prescaler_reg + PW'(1);
                if (pwm_reg != 4'hF) begin
                    pwm_reg <= pwm_reg + 4'd1;
                end
            end

            // Swap first so a coincident new capture lands in pending for next frame.
            if (wrap_tick && pend_v_reg) begin
                live_reg   <= pending_reg;
                pend_v_reg <= 1'b0;
            end
            if (rise) begin
                pending_reg <= bus.data_in;
                pend_v_reg  <= 1'b1;
            end

            seg_n_reg <= seg_next;
            dig_n_reg <= dig_next;
        end
    end

    assign bus.load_ack    = load_ack_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.seg_n       = seg_n_reg;
    assign bus.dig_n       = dig_n_reg;
endmodule
